// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M sequencer: funct3 encodings, one-hot FSM states,
// divider iteration count and the divide special-case helpers.
package muldiv_seq_pkg;

  localparam int XLEN = 32;
  localparam logic [5:0] DIV_ITER = 6'd32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_MUL_ISSUE = 6'b000010,
    S_MUL_WAIT  = 6'b000100,
    S_DIV_RUN   = 6'b001000,
    S_DIV_FIX   = 6'b010000,
    S_DONE      = 6'b100000
  } state_t;

  // Divide by zero, or the single signed overflow case INT_MIN / -1.
  function automatic logic div_special(input logic is_signed,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    return (b == '0) || (is_signed && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1);
  endfunction

  function automatic logic [XLEN-1:0] div_special_result(input logic rem_sel,
                                                         input logic [XLEN-1:0] a,
                                                         input logic [XLEN-1:0] b);
    if (b == '0) return rem_sel ? a : '1;
    return rem_sel ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Core-side request/response bundle of the M-extension sequencer.
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd_out;

  modport master (output start, funct3, rs1, rs2, input busy, done, rd_out);
  modport slave  (input start, funct3, rs1, rs2, output busy, done, rd_out);
endinterface

// File: rtl/muldiv_seq_div.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle after go.
module div_r2_core
  import muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg, rem_reg, dvs_reg;
  logic [5:0]      cnt_reg;
  logic [XLEN:0]   shifted, trial;

  // Partial remainder shifted left with the next dividend bit; bit XLEN of trial is the borrow.
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
    end else if (go) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
      cnt_reg <= DIV_ITER;
    end else if (cnt_reg != 6'd0) begin
      cnt_reg <= cnt_reg - 6'd1;
      if (!trial[XLEN]) begin
        rem_reg <= trial[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  assign last      = (cnt_reg == 6'd1);
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M execute sequencer: issues MUL* to the external shift multiplier and runs DIV*/REM*
// on the embedded divider, returning one rd value per start with a busy/done handshake.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter bit DIV_EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_seq_if.slave      core,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_ua,
  output logic             mul_ub,
  output logic             mul_hm,
  output logic             mul_load,
  input  logic             mul_busy,
  input  logic [WIDTH-1:0] mul_out
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rs1_reg, rs2_reg, rd_reg;
  logic [1:0]       op_reg;
  logic             accept, is_div, div_signed, early, div_go, div_last;
  logic [WIDTH-1:0] div_dividend, div_divisor, quo, rem, early_val, fix_val;
  logic             q_neg, r_neg;

  assign accept       = (state_reg == S_IDLE) && core.start;
  assign is_div       = core.funct3[2];
  assign div_signed   = !core.funct3[0];
  assign early        = DIV_EARLY_OUT && is_div && div_special(div_signed, core.rs1, core.rs2);
  assign div_go       = accept && is_div && !early;
  assign div_dividend = (div_signed && core.rs1[31]) ? -core.rs1 : core.rs1;
  assign div_divisor  = (div_signed && core.rs2[31]) ? -core.rs2 : core.rs2;
  assign early_val    = div_special_result(core.funct3[1], core.rs1, core.rs2);

  div_r2_core u_div (
    .clk       (clk),
    .reset     (reset),
    .go        (div_go),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .last      (div_last),
    .quotient  (quo),
    .remainder (rem)
  );

  // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
  assign q_neg   = !op_reg[0] && (rs1_reg[31] ^ rs2_reg[31]) && (rs2_reg != '0);
  assign r_neg   = !op_reg[0] && rs1_reg[31];
  assign fix_val = op_reg[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (core.start) begin
          if (!is_div)    state_next = S_MUL_ISSUE;
          else if (early) state_next = S_DONE;
          else            state_next = S_DIV_RUN;
        end
      end
      S_MUL_ISSUE: state_next = S_MUL_WAIT;
      S_MUL_WAIT:  if (!mul_busy) state_next = S_DONE;
      S_DIV_RUN:   if (div_last) state_next = S_DIV_FIX;
      S_DIV_FIX:   state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    core.busy = (state_reg == S_MUL_ISSUE) || (state_reg == S_MUL_WAIT) ||
                (state_reg == S_DIV_RUN)   || (state_reg == S_DIV_FIX);
    core.done = (state_reg == S_DONE);
    mul_load  = (state_reg == S_MUL_ISSUE);
  end

  // Operands are captured only on acceptance, so they stay stable for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_reg <= '0;
      rs2_reg <= '0;
      op_reg  <= '0;
      rd_reg  <= '0;
      mul_ua  <= 1'b0;
      mul_ub  <= 1'b0;
      mul_hm  <= 1'b0;
    end else begin
      if (accept) begin
        rs1_reg <= core.rs1;
        rs2_reg <= core.rs2;
        op_reg  <= core.funct3[1:0];
        if (!is_div) begin
          mul_ua <= core.funct3[1];
          mul_ub <= (core.funct3 == F3_MULHU);
          mul_hm <= (core.funct3[1:0] != 2'b00);
        end
      end
      if (accept && early)                            rd_reg <= early_val;
      else if (state_reg == S_MUL_WAIT && !mul_busy)  rd_reg <= mul_out;
      else if (state_reg == S_DIV_FIX)                rd_reg <= fix_val;
    end
  end

  assign mul_a       = rs2_reg;
  assign mul_b       = rs1_reg;
  assign core.rd_out = rd_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with a behavioural shift-multiplier model and an
// arithmetic RV32M reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mul_a, mul_b, mul_out;
  logic        mul_ua, mul_ub, mul_hm, mul_load, mul_busy;

  muldiv_seq_if bus();

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .core     (bus),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_ua   (mul_ua),
    .mul_ub   (mul_ub),
    .mul_hm   (mul_hm),
    .mul_load (mul_load),
    .mul_busy (mul_busy),
    .mul_out  (mul_out)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Multiplier model: reloads take m_lat busy cycles, identical operands skip the load.
  int          m_lat = 1;
  int          m_cnt;
  logic        m_valid, m_skip;
  logic [31:0] m_a_prev, m_b_prev;
  logic [63:0] m_prod;

  function automatic logic [63:0] prod64(input logic [31:0] a, input logic ua,
                                         input logic [31:0] b, input logic ub);
    logic [63:0] ea, eb;
    ea = ua ? {32'b0, a} : {{32{a[31]}}, a};
    eb = ub ? {32'b0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  assign m_skip   = m_valid && (mul_a == m_a_prev) && (mul_b == m_b_prev);
  assign mul_busy = (m_cnt != 0) || (mul_load && !m_skip);
  assign mul_out  = mul_hm ? m_prod[63:32] : m_prod[31:0];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    <= 0;
      m_valid  <= 1'b0;
      m_a_prev <= '0;
      m_b_prev <= '0;
      m_prod   <= '0;
    end else begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (mul_load) begin
        m_prod   <= prod64(mul_a, mul_ua, mul_b, mul_ub);
        m_a_prev <= mul_a;
        m_b_prev <= mul_b;
        m_valid  <= 1'b1;
        if (!m_skip) m_cnt <= m_lat;
      end
    end
  end

  // RV32M reference computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  logic        prev_valid = 1'b0;
  logic [31:0] prev_rs1, prev_rs2;
  logic [31:0] exp_prev_rd = '0;

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input string tag);
    int exp_cyc, lat, done_cyc, n_done, n_load;
    bit hold_ok, busy_ok;
    lat = $urandom_range(1, 8);
    m_lat = lat;
    if (f3[2])
      exp_cyc = (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 34;
    else begin
      exp_cyc = (prev_valid && a == prev_rs1 && b == prev_rs2) ? 3 : lat + 3;
      prev_valid = 1'b1;
      prev_rs1 = a;
      prev_rs2 = b;
    end
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    done_cyc = 0; n_done = 0; n_load = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (mul_load === 1'b1) n_load++;
      if (done_cyc == 0 && bus.rd_out !== exp_prev_rd) hold_ok = 1'b0;
      if (bus.busy !== (done_cyc == 0)) busy_ok = 1'b0;
      if (done_cyc != 0 && c >= done_cyc + 1) break;
      // Junk requests while busy must be neither accepted nor latched.
      bus.start  = (c < exp_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.funct3 = 3'($urandom);
      bus.rs1    = $urandom;
      bus.rs2    = $urandom;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    $display("[TB] %s f3=%0d rs1=%h rs2=%h rd=%h done_cycle=%0d", tag, f3, a, b, bus.rd_out, done_cyc);
    tests_run++;
    if (bus.rd_out !== exp_rd) begin
      tests_failed++; $display("FAIL %s rd_out: got %h expected %h", tag, bus.rd_out, exp_rd);
    end
    tests_run++;
    if (done_cyc !== exp_cyc) begin
      tests_failed++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_cyc);
    end
    tests_run++;
    if (n_done !== 1) begin
      tests_failed++; $display("FAIL %s done_pulses: got %0d expected 1", tag, n_done);
    end
    tests_run++;
    if (n_load !== (f3[2] ? 0 : 1)) begin
      tests_failed++; $display("FAIL %s mul_load_cycles: got %0d expected %0d", tag, n_load, f3[2] ? 0 : 1);
    end
    tests_run++;
    if (!hold_ok) begin
      tests_failed++; $display("FAIL %s rd_hold: got changed expected %h", tag, exp_prev_rd);
    end
    tests_run++;
    if (!busy_ok) begin
      tests_failed++; $display("FAIL %s busy_profile: got bad expected high until done", tag);
    end
    exp_prev_rd = exp_rd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, mul_load} !== 3'b000 || bus.rd_out !== 32'h0 || mul_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held: got busy=%b done=%b load=%b rd=%h a=%h expected zeros",
               bus.busy, bus.done, mul_load, bus.rd_out, mul_a);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.rd_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy=%b done=%b rd=%h expected 0 0 0", bus.busy, bus.done, bus.rd_out);
    end
  endtask

  task automatic test_mul_directed();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
  endtask

  task automatic test_mul_repeat();
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_repeat");
  endtask

  task automatic test_div_directed();
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
  endtask

  task automatic test_div_special();
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_by_zero");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by_zero");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_overflow");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_overflow");
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: if (prev_valid) begin a = prev_rs1; b = prev_rs2; end
        3: b = $urandom_range(1, 17);
        default: ;
      endcase
      run_op(f3, a, b, ref_result(f3, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2, r1, r2;
    int d1, d2;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    e1 = ref_result(3'd5, a1, b1);
    e2 = ref_result(3'd7, a2, b2);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1 = a1; bus.rs2 = b1;
    @(posedge clk); #1;
    bus.funct3 = 3'd7; bus.rs1 = a2; bus.rs2 = b2;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 90; c++) begin
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin d1 = c; r1 = bus.rd_out; end
        else if (d2 == 0) begin d2 = c; r2 = bus.rd_out; end
      end
      if (c == 36) bus.start = 1'b0;
      if (d2 != 0) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    $display("[TB] back_to_back divu=%h@%0d remu=%h@%0d", r1, d1, r2, d2);
    tests_run++;
    if (d1 !== 34) begin tests_failed++; $display("FAIL b2b_first_cycle: got %0d expected 34", d1); end
    tests_run++;
    if (r1 !== e1) begin tests_failed++; $display("FAIL b2b_first_rd: got %h expected %h", r1, e1); end
    tests_run++;
    if (d2 !== 69) begin tests_failed++; $display("FAIL b2b_second_cycle: got %0d expected 69", d2); end
    tests_run++;
    if (r2 !== e2) begin tests_failed++; $display("FAIL b2b_second_rd: got %h expected %h", r2, e2); end
    exp_prev_rd = e2;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    int stray_done;
    a = $urandom; b = $urandom_range(1, 50000);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      bus.start = (c == 5);
      if (c == 5) begin bus.funct3 = 3'd0; bus.rs1 = $urandom; bus.rs2 = $urandom; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL mid_busy_before_reset: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, mul_load} !== 3'b000 || bus.rd_out !== exp_prev_rd * 0) begin
      tests_failed++;
      $display("FAIL mid_reset: got busy=%b done=%b load=%b rd=%h expected 0 0 0 0",
               bus.busy, bus.done, mul_load, bus.rd_out);
    end
    exp_prev_rd = '0;
    prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    stray_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray_done++;
    end
    tests_run++;
    if (stray_done !== 0) begin
      tests_failed++; $display("FAIL post_reset_idle: got %0d active cycles expected 0", stray_done);
    end
    a = $urandom; b = $urandom;
    run_op(3'd0, a, b, ref_result(3'd0, a, b), "after_reset_mul");
    a = $urandom; b = $urandom_range(1, 300);
    run_op(3'd6, a, b, ref_result(3'd6, a, b), "after_reset_rem");
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1 = '0; bus.rs2 = '0;
    test_reset();
    test_mul_directed();
    test_mul_repeat();
    test_div_directed();
    test_div_special();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
